// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit: FSM encoding, default
// stage indices and a counter-width helper.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   localparam int DEF_NSTAGE = 5;
   localparam int DEF_ADDR_W = 32;

   // $clog2 clamped to one bit so degenerate parameters still give a legal vector
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-source / pipeline-register bundle of the pipeline control unit.
// The master side drives requests; the slave side (pipe_ctrl) answers.
interface pipe_ctrl_if #(
   parameter int NSTAGE = pipe_pkg::DEF_NSTAGE,
   parameter int ADDR_W = pipe_pkg::DEF_ADDR_W
);
   logic              jump_en_i;
   logic [ADDR_W-1:0] jump_addr_i;
   logic              trap_en_i;
   logic [ADDR_W-1:0] trap_addr_i;
   logic [NSTAGE-1:0] hold_req_i;
   logic              halt_req_i;
   logic              resume_i;

   logic              jump_en_o;
   logic [ADDR_W-1:0] jump_addr_o;
   logic [NSTAGE-1:0] stall_o;
   logic [NSTAGE-1:0] flush_o;
   logic              halted_o;
   logic              timeout_o;

   modport master (
      output jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
             hold_req_i, halt_req_i, resume_i,
      input  jump_en_o, jump_addr_o, stall_o, flush_o, halted_o, timeout_o
   );

   modport slave (
      input  jump_en_i, jump_addr_i, trap_en_i, trap_addr_i,
             hold_req_i, halt_req_i, resume_i,
      output jump_en_o, jump_addr_o, stall_o, flush_o, halted_o, timeout_o
   );
endinterface

// File: rtl/pipe_ctrl_hold_encoder.sv
// Priority encoder for per-stage hold requests: highest requesting stage,
// a valid flag, and the thermometer mask of every stage at or below it.
module hold_encoder
   import pipe_pkg::*;
#(
   parameter int NSTAGE = DEF_NSTAGE
) (
   input  logic [NSTAGE-1:0]        i_hold,
   output logic                     o_valid,
   output logic [cnt_w(NSTAGE)-1:0] o_idx,
   output logic [NSTAGE-1:0]        o_mask
);
   localparam int IDX_W = cnt_w(NSTAGE);

   // NOTE: every output gets a default before the loops; a path that leaves a
   // combinational output unassigned infers a latch.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      o_mask  = '0;
      for (int s = 0; s < NSTAGE; s++) begin
         if (i_hold[s]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(s);
         end
      end
      for (int s = 0; s < NSTAGE; s++) begin
         o_mask[s] = |(i_hold >> s);
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: redirect forwarding, hold-to-stall/flush translation,
// multi-cycle redirect flush, debug halt/drain/resume and hold timeout.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int NSTAGE     = DEF_NSTAGE,
   parameter int JUMP_STAGE = STG_EX,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FLUSH_CYC  = 1,
   parameter int TIMEOUT    = 256
) (
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave ctl
);
   localparam int IDX_W = cnt_w(NSTAGE);
   localparam int FC_W  = cnt_w(FLUSH_CYC);
   localparam int DC_W  = cnt_w(NSTAGE);
   localparam int TO_W  = cnt_w(TIMEOUT + 1);

   localparam logic [FC_W-1:0]   FC_LOAD   = FC_W'(FLUSH_CYC - 1);
   localparam logic [DC_W-1:0]   DRAIN_PRE = DC_W'(NSTAGE - 2);
   localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
   localparam logic [NSTAGE-1:0] PRE_JUMP  = {NSTAGE{1'b1}} >> (NSTAGE - JUMP_STAGE);

   state_e            r_state,     w_state_nxt;
   logic [FC_W-1:0]   r_flush_cnt, w_flush_cnt_nxt;
   logic [DC_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt,    w_to_cnt_nxt;

   logic              w_hold_valid;
   logic [IDX_W-1:0]  w_hold_idx;
   logic [NSTAGE-1:0] w_hold_mask;
   logic [NSTAGE-1:0] w_bubble;
   logic              w_accept;
   logic              w_jump_en;
   logic [ADDR_W-1:0] w_jump_addr;
   logic [NSTAGE-1:0] w_stall;
   logic [NSTAGE-1:0] w_flush;
   logic              w_halted;

   hold_encoder #(.NSTAGE(NSTAGE)) u_hold_enc (
      .i_hold  (ctl.hold_req_i),
      .o_valid (w_hold_valid),
      .o_idx   (w_hold_idx),
      .o_mask  (w_hold_mask)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = (r_flush_cnt != '0) ? r_flush_cnt - 1'b1 : r_flush_cnt;
      w_drain_cnt_nxt = r_drain_cnt;
      w_to_cnt_nxt    = r_to_cnt;
      w_bubble        = '0;
      w_accept        = 1'b0;
      w_jump_en       = 1'b0;
      w_jump_addr     = '0;
      w_stall         = '0;
      w_flush         = '0;
      w_halted        = 1'b0;

      for (int k = 1; k < NSTAGE; k++) begin
         if (w_hold_valid && (w_hold_idx == IDX_W'(k - 1))) w_bubble[k] = 1'b1;
      end

      if (r_state != ST_HALTED) begin
         if (!w_hold_valid)          w_to_cnt_nxt = '0;
         else if (r_to_cnt != TO_MAX) w_to_cnt_nxt = r_to_cnt + 1'b1;
      end

      case (r_state)
         ST_HALTED: begin
            w_stall  = '1;
            w_halted = 1'b1;
            if (ctl.resume_i) w_state_nxt = ST_RUN;
         end
         default: begin
            w_stall  = w_hold_mask;
            w_flush  = w_bubble;
            w_accept = (ctl.jump_en_i || ctl.trap_en_i) && !w_hold_mask[JUMP_STAGE];
            if (w_accept) begin
               w_jump_en       = 1'b1;
               w_jump_addr     = ctl.trap_en_i ? ctl.trap_addr_i : ctl.jump_addr_i;
               w_flush_cnt_nxt = FC_LOAD;
            end
            if (w_accept || (r_flush_cnt != '0)) w_flush = w_flush | PRE_JUMP;

            if (r_state == ST_RUN) begin
               if (ctl.halt_req_i) w_state_nxt = ST_DRAIN;
            end else if (r_state == ST_DRAIN) begin
               w_stall[0] = 1'b1;
               w_flush[1] = 1'b1;
               if (!ctl.halt_req_i) begin
                  w_state_nxt     = ST_RUN;
                  w_drain_cnt_nxt = '0;
               end else if (w_accept) begin
                  w_drain_cnt_nxt = '0;
               end else if (!w_hold_valid) begin
                  // Halting on the edge that would make the count NSTAGE-1
                  if (r_drain_cnt == DRAIN_PRE) begin
                     w_state_nxt     = ST_HALTED;
                     w_drain_cnt_nxt = '0;
                  end else begin
                     w_drain_cnt_nxt = r_drain_cnt + 1'b1;
                  end
               end
            end else begin
               w_state_nxt = ST_RUN;
            end
            w_stall = w_stall & ~w_flush;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_drain_cnt <= '0;
         r_to_cnt    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         r_drain_cnt <= w_drain_cnt_nxt;
         r_to_cnt    <= w_to_cnt_nxt;
      end
   end

   assign ctl.jump_en_o   = rst ? 1'b0 : w_jump_en;
   assign ctl.jump_addr_o = rst ? '0   : w_jump_addr;
   assign ctl.stall_o     = rst ? '1   : w_stall;
   assign ctl.flush_o     = rst ? '1   : w_flush;
   assign ctl.halted_o    = rst ? 1'b0 : w_halted;
   assign ctl.timeout_o   = (TIMEOUT != 0) && !rst && (r_to_cnt == TO_MAX);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Vector/scoreboard bench for pipe_ctrl with NSTAGE=5, JUMP_STAGE=2,
// FLUSH_CYC=3, TIMEOUT=4; jump target fixed at 0x80, trap vector at 0x100.
module tb_pipe_ctrl;
   import pipe_pkg::*;

   localparam logic [4:0] ALL = 5'b11111;

   typedef struct {
      logic       rst;
      logic       je;
      logic       te;
      logic [4:0] hold;
      logic       halt;
      logic       resume;
      logic       x_je;
      logic [31:0] x_addr;
      logic [4:0] x_stall;
      logic [4:0] x_flush;
      logic       x_halted;
      logic       x_to;
      int         id;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.NSTAGE(5), .ADDR_W(32)) bus ();

   pipe_ctrl #(
      .NSTAGE(5), .JUMP_STAGE(2), .ADDR_W(32), .FLUSH_CYC(3), .TIMEOUT(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus)
   );

   vec_t sb[$];
   vec_t tbl[$];
   vec_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   vec_id   = 0;

   function automatic vec_t v(input logic r, je, te, input logic [4:0] hold,
                              input logic halt, res, xje, input logic [31:0] xa,
                              input logic [4:0] xst, xfl, input logic xh, xto);
      vec_t t;
      t.rst = r;  t.je = je; t.te = te; t.hold = hold; t.halt = halt; t.resume = res;
      t.x_je = xje; t.x_addr = xa; t.x_stall = xst; t.x_flush = xfl;
      t.x_halted = xh; t.x_to = xto; t.id = 0;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic apply(input vec_t x);
      @(posedge clk);
      #1;
      rst             = x.rst;
      bus.jump_en_i   = x.je;
      bus.trap_en_i   = x.te;
      bus.hold_req_i  = x.hold;
      bus.halt_req_i  = x.halt;
      bus.resume_i    = x.resume;
      x.id            = vec_id;
      vec_id++;
      sb.push_back(x);
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         check($sformatf("v%0d jump_en",   mon_e.id), 32'(bus.jump_en_o), 32'(mon_e.x_je));
         check($sformatf("v%0d jump_addr", mon_e.id), bus.jump_addr_o,    mon_e.x_addr);
         check($sformatf("v%0d stall",     mon_e.id), 32'(bus.stall_o),   32'(mon_e.x_stall));
         check($sformatf("v%0d flush",     mon_e.id), 32'(bus.flush_o),   32'(mon_e.x_flush));
         check($sformatf("v%0d halted",    mon_e.id), 32'(bus.halted_o),  32'(mon_e.x_halted));
         check($sformatf("v%0d timeout",   mon_e.id), 32'(bus.timeout_o), 32'(mon_e.x_to));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.jump_en_i   = 1'b0;
      bus.jump_addr_i = 32'h80;
      bus.trap_en_i   = 1'b0;
      bus.trap_addr_i = 32'h100;
      bus.hold_req_i  = '0;
      bus.halt_req_i  = 1'b0;
      bus.resume_i    = 1'b0;

      // rst, je, te, hold, halt, res | je_o, addr, stall, flush, halted, timeout
      tbl.push_back(v(1,0,0,5'b00000,0,0, 0,0,     ALL,     ALL,     0,0));
      tbl.push_back(v(1,0,0,5'b00000,0,0, 0,0,     ALL,     ALL,     0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,1,5'b00000,0,0, 1,'h100, 5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,0,5'b01000,0,0, 0,0,     5'b01111,5'b10000,0,0));
      tbl.push_back(v(0,1,0,5'b01000,0,0, 0,0,     5'b01111,5'b10000,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,0,0,5'b00001,0,0, 0,0,     5'b00001,5'b00010,0,0));
      tbl.push_back(v(0,0,0,5'b10000,0,0, 0,0,     5'b11111,5'b00000,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00010,0,0, 0,0,     5'b00000,5'b00111,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00011,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,1,0,5'b00000,0,0, 1,'h80,  5'b00000,5'b00011,0,0));
      tbl.push_back(v(1,0,0,5'b00000,0,0, 0,0,     ALL,     ALL,     0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,1, 0,0,     5'b00000,5'b00000,0,0));
      tbl.push_back(v(0,0,0,5'b00000,0,0, 0,0,     5'b00000,5'b00000,0,0));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Halt together with a redirect, flush overlapping the first DRAIN cycles
      apply(v(0,1,0,5'b00000,1,0, 1,'h80, 5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00001,5'b00010,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00001,5'b00010,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,1,1,5'b00000,1,0, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,0,0,5'b00100,1,0, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,0,0,5'b00000,0,1, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00000,5'b00000,0,0));

      // Drain paused by a hold, restarted by a redirect, abandoned, then redone
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00000,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00001,5'b00010,0,0));
      apply(v(0,0,0,5'b00100,1,0, 0,0,    5'b00101,5'b01010,0,0));
      apply(v(0,1,0,5'b00000,1,0, 1,'h80, 5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00011,0,0));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00001,5'b00010,0,0));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00000,5'b00000,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    5'b00000,5'b00000,0,0));
      for (int i = 0; i < 4; i++)
         apply(v(0,0,0,5'b00000,1,0, 0,0, 5'b00001,5'b00010,0,0));
      apply(v(0,0,0,5'b00000,1,0, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,0,0,5'b00000,0,1, 0,0,    ALL,     5'b00000,1,0));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00000,5'b00000,0,0));

      // Hold timeout: rises on the fifth held cycle, clears after the hold drops
      for (int i = 0; i < 6; i++)
         apply(v(0,0,0,5'b00100,0,0, 0,0, 5'b00111,5'b01000,0,(i >= 4)));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00000,5'b00000,0,1));
      apply(v(0,0,0,5'b00000,0,0, 0,0,    5'b00000,5'b00000,0,0));

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
